// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// Covers FSM states, event kinds, interrupt codes and the mstatus bit layout.
package trap_ctrl_pkg;

    localparam int unsigned XLEN_C = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_REDIR = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        EV_EXC  = 2'd0,
        EV_IRQ  = 2'd1,
        EV_MRET = 2'd2
    } kind_e;

    localparam logic [3:0] CODE_MEI = 4'd11;
    localparam logic [3:0] CODE_MSI = 4'd3;
    localparam logic [3:0] CODE_MTI = 4'd7;

    localparam int unsigned MS_MIE    = 3;
    localparam int unsigned MS_MPIE   = 7;
    localparam int unsigned MS_MPP_LO = 11;
    localparam int unsigned MS_MPP_HI = 12;

    // Trap entry stacks MIE into MPIE, disables interrupts and records M-mode as previous.
    function automatic logic [XLEN_C-1:0] mstatus_on_trap(input logic [XLEN_C-1:0] ms);
        logic [XLEN_C-1:0] res;
        res                      = ms;
        res[MS_MPIE]             = ms[MS_MIE];
        res[MS_MIE]              = 1'b0;
        res[MS_MPP_HI:MS_MPP_LO] = 2'b11;
        return res;
    endfunction

    function automatic logic [XLEN_C-1:0] mstatus_on_mret(input logic [XLEN_C-1:0] ms);
        logic [XLEN_C-1:0] res;
        res                      = ms;
        res[MS_MIE]              = ms[MS_MPIE];
        res[MS_MPIE]             = 1'b1;
        res[MS_MPP_HI:MS_MPP_LO] = 2'b11;
        return res;
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Pipeline/CSR-side signal bundle of trap_ctrl. The master drives events and CSR values,
// the slave (trap_ctrl) returns the CSR write port, fetch redirect and stall.
interface trap_ctrl_if;
    import trap_ctrl_pkg::*;

    logic              exc_valid_i;
    logic [3:0]        exc_cause_i;
    logic [XLEN_C-1:0] exc_pc_i;
    logic [XLEN_C-1:0] exc_tval_i;
    logic              mret_i;
    logic              irq_ok_i;
    logic [XLEN_C-1:0] next_pc_i;
    logic              meip_i;
    logic              msip_i;
    logic              mtip_i;
    logic [XLEN_C-1:0] mstatus_i;
    logic [XLEN_C-1:0] mie_i;
    logic [XLEN_C-1:0] mtvec_i;
    logic [XLEN_C-1:0] mepc_i;
    logic [XLEN_C-1:0] mcause_i;
    logic [XLEN_C-1:0] mtval_i;
    logic              we_exc_o;
    logic [XLEN_C-1:0] mepc_d_o;
    logic [XLEN_C-1:0] mcause_d_o;
    logic [XLEN_C-1:0] mtval_d_o;
    logic [XLEN_C-1:0] mstatus_d_o;
    logic              redirect_o;
    logic [XLEN_C-1:0] redirect_pc_o;
    logic              stall_o;

    modport master (
        output exc_valid_i, exc_cause_i, exc_pc_i, exc_tval_i, mret_i, irq_ok_i, next_pc_i,
               meip_i, msip_i, mtip_i, mstatus_i, mie_i, mtvec_i, mepc_i, mcause_i, mtval_i,
        input  we_exc_o, mepc_d_o, mcause_d_o, mtval_d_o, mstatus_d_o,
               redirect_o, redirect_pc_o, stall_o
    );

    modport slave (
        input  exc_valid_i, exc_cause_i, exc_pc_i, exc_tval_i, mret_i, irq_ok_i, next_pc_i,
               meip_i, msip_i, mtip_i, mstatus_i, mie_i, mtvec_i, mepc_i, mcause_i, mtval_i,
        output we_exc_o, mepc_d_o, mcause_d_o, mtval_d_o, mstatus_d_o,
               redirect_o, redirect_pc_o, stall_o
    );
endinterface

// File: rtl/trap_ctrl_irq_prio_enc.sv
// Interrupt-line synchroniser plus fixed-priority encoder (MEI > MSI > MTI).
// IRQ_SYNC_STAGES = 0 bypasses the synchroniser.
module trap_ctrl_irq_prio_enc
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned IRQ_SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_meip,
    input  logic       i_msip,
    input  logic       i_mtip,
    input  logic [2:0] i_mie_bits,
    input  logic       i_glb_mie,
    input  logic       i_irq_ok,
    output logic       o_irq_valid,
    output logic [3:0] o_irq_code
);

    logic [2:0] w_raw;
    logic [2:0] w_sync;
    logic [2:0] w_pend;

    assign w_raw = {i_meip, i_msip, i_mtip};

    generate
        if (IRQ_SYNC_STAGES == 0) begin : g_nosync
            assign w_sync = w_raw;
        end else begin : g_sync
            logic [2:0] r_sync [IRQ_SYNC_STAGES];

            // Shift register of synchroniser flops, one bit per interrupt line
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < int'(IRQ_SYNC_STAGES); i++) begin
                        r_sync[i] <= 3'b000;
                    end
                end else begin
                    r_sync[0] <= w_raw;
                    for (int i = 1; i < int'(IRQ_SYNC_STAGES); i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_sync = r_sync[IRQ_SYNC_STAGES-1];
        end
    endgenerate

    assign w_pend = w_sync & i_mie_bits;

    // Fixed-priority pick among the enabled pending lines
    always_comb begin
        o_irq_code  = 4'd0;
        o_irq_valid = i_glb_mie & i_irq_ok & (|w_pend);
        if (w_pend[2]) begin
            o_irq_code = CODE_MEI;
        end else if (w_pend[1]) begin
            o_irq_code = CODE_MSI;
        end else if (w_pend[0]) begin
            o_irq_code = CODE_MTI;
        end else begin
            o_irq_code = 4'd0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / MRET sequencer: IDLE -> WRITE (CSR strobe) -> REDIR -> IDLE.
// Optional TRAP_VECTORED_EN: interrupts jump to mtvec base + 4*code when mtvec mode is 2'b01.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned IRQ_SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    trap_ctrl_if.slave  bus
);

    state_e            r_state;
    state_e            w_state_nxt;
    kind_e             r_kind;
    logic [3:0]        r_cause;
    logic [XLEN-1:2]   r_pc;
    logic [XLEN-1:0]   r_tval;
    logic [XLEN-1:0]   r_target;

    logic              w_irq_valid;
    logic [3:0]        w_irq_code;
    logic              w_event;
    logic              w_accept;
    kind_e             w_kind;
    logic [3:0]        w_cause;
    logic [XLEN-1:2]   w_pc;
    logic [XLEN-1:0]   w_tval;
    logic [XLEN-1:0]   w_base;
    logic [XLEN-1:0]   w_target;

    logic              w_we_exc;
    logic [XLEN-1:0]   w_mepc_d;
    logic [XLEN-1:0]   w_mcause_d;
    logic [XLEN-1:0]   w_mtval_d;
    logic [XLEN-1:0]   w_mstatus_d;
    logic              w_redirect;
    logic [XLEN-1:0]   w_redirect_pc;
    logic              w_stall;
    logic              w_unused_bits;

    trap_ctrl_irq_prio_enc #(
        .IRQ_SYNC_STAGES (IRQ_SYNC_STAGES)
    ) u_irq_prio_enc (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_meip      (bus.meip_i),
        .i_msip      (bus.msip_i),
        .i_mtip      (bus.mtip_i),
        .i_mie_bits  ({bus.mie_i[11], bus.mie_i[3], bus.mie_i[7]}),
        .i_glb_mie   (bus.mstatus_i[MS_MIE]),
        .i_irq_ok    (bus.irq_ok_i),
        .o_irq_valid (w_irq_valid),
        .o_irq_code  (w_irq_code)
    );

    assign w_base        = {bus.mtvec_i[XLEN-1:2], 2'b00};
    assign w_accept      = (r_state == ST_IDLE) && w_event && !rst_i;
    assign w_unused_bits = ^{bus.exc_pc_i[1:0], bus.next_pc_i[1:0], bus.mtvec_i[1:0], bus.mie_i};

    // Event arbitration: exception, then enabled interrupt, then MRET
    always_comb begin
        w_event  = 1'b0;
        w_kind   = EV_EXC;
        w_cause  = 4'd0;
        w_pc     = '0;
        w_tval   = '0;
        w_target = w_base;
        if (bus.exc_valid_i) begin
            w_event = 1'b1;
            w_kind  = EV_EXC;
            w_cause = bus.exc_cause_i;
            w_pc    = bus.exc_pc_i[XLEN-1:2];
            w_tval  = bus.exc_tval_i;
        end else if (w_irq_valid) begin
            w_event = 1'b1;
            w_kind  = EV_IRQ;
            w_cause = w_irq_code;
            w_pc    = bus.next_pc_i[XLEN-1:2];
        end else if (bus.mret_i) begin
            w_event = 1'b1;
            w_kind  = EV_MRET;
        end else begin
            w_event = 1'b0;
        end

        if (w_kind == EV_MRET) begin
            w_target = {bus.mepc_i[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
        end else if ((w_kind == EV_IRQ) && (bus.mtvec_i[1:0] == 2'b01)) begin
            w_target = w_base + {{(XLEN-6){1'b0}}, w_cause, 2'b00};
`endif
        end else begin
            w_target = w_base;
        end
    end

    // State register and event capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_kind   <= EV_EXC;
            r_cause  <= 4'd0;
            r_pc     <= '0;
            r_tval   <= '0;
            r_target <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_kind   <= w_kind;
                r_cause  <= w_cause;
                r_pc     <= w_pc;
                r_tval   <= w_tval;
                r_target <= w_target;
            end
        end
    end

    // Next state and per-state outputs; reset forces every output low at once
    always_comb begin
        w_state_nxt   = r_state;
        w_we_exc      = 1'b0;
        w_mepc_d      = '0;
        w_mcause_d    = '0;
        w_mtval_d     = '0;
        w_mstatus_d   = '0;
        w_redirect    = 1'b0;
        w_redirect_pc = '0;
        w_stall       = 1'b0;
        case (r_state)
            ST_IDLE:  w_state_nxt = w_accept ? ST_WRITE : ST_IDLE;
            ST_WRITE: w_state_nxt = ST_REDIR;
            ST_REDIR: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (!rst_i) begin
            case (r_state)
                ST_IDLE: begin
                    w_stall = w_event;
                end
                ST_WRITE: begin
                    w_we_exc = 1'b1;
                    w_stall  = 1'b1;
                    if (r_kind == EV_MRET) begin
                        w_mepc_d    = bus.mepc_i;
                        w_mcause_d  = bus.mcause_i;
                        w_mtval_d   = bus.mtval_i;
                        w_mstatus_d = mstatus_on_mret(bus.mstatus_i);
                    end else begin
                        w_mepc_d    = {r_pc, 2'b00};
                        w_mcause_d  = {(r_kind == EV_IRQ), 27'd0, r_cause};
                        w_mtval_d   = r_tval;
                        w_mstatus_d = mstatus_on_trap(bus.mstatus_i);
                    end
                end
                ST_REDIR: begin
                    w_redirect    = 1'b1;
                    w_redirect_pc = r_target;
                    w_stall       = 1'b1;
                end
                default: begin
                    w_stall = 1'b0;
                end
            endcase
        end else begin
            w_stall = 1'b0;
        end
    end

    assign bus.we_exc_o      = w_we_exc;
    assign bus.mepc_d_o      = w_mepc_d;
    assign bus.mcause_d_o    = w_mcause_d;
    assign bus.mtval_d_o     = w_mtval_d;
    assign bus.mstatus_d_o   = w_mstatus_d;
    assign bus.redirect_o    = w_redirect;
    assign bus.redirect_pc_o = w_redirect_pc;
    assign bus.stall_o       = w_stall;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: directed vectors push expected CSR writes and redirects,
// an independent monitor compares them whenever the DUT strobes we_exc_o or redirect_o.
module tb_trap_ctrl;

    typedef struct packed {
        logic        is_redir;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mtval;
        logic [31:0] mstatus;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    trap_ctrl_if bus ();

    trap_ctrl #(
        .XLEN            (32),
        .IRQ_SYNC_STAGES (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_trap(input logic [31:0] mepc, input logic [31:0] mcause,
                             input logic [31:0] mtval, input logic [31:0] mstatus,
                             input logic [31:0] target);
        sb_q.push_back({1'b0, mepc, mcause, mtval, mstatus, 32'h0});
        sb_q.push_back({1'b1, 32'h0, 32'h0, 32'h0, 32'h0, target});
    endtask

    task automatic clear_events();
        bus.exc_valid_i = 1'b0;
        bus.mret_i      = 1'b0;
        bus.meip_i      = 1'b0;
        bus.msip_i      = 1'b0;
        bus.mtip_i      = 1'b0;
    endtask

    task automatic idle_inputs();
        clear_events();
        bus.exc_cause_i = 4'd0;
        bus.exc_pc_i    = 32'h0;
        bus.exc_tval_i  = 32'h0;
        bus.irq_ok_i    = 1'b0;
        bus.next_pc_i   = 32'h0;
        bus.mstatus_i   = 32'h0;
        bus.mie_i       = 32'h0;
        bus.mtvec_i     = 32'h0;
        bus.mepc_i      = 32'h0;
        bus.mcause_i    = 32'h0;
        bus.mtval_i     = 32'h0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"},   {31'd0, bus.stall_o},    32'd0);
        chk({tag, "_we"},      {31'd0, bus.we_exc_o},   32'd0);
        chk({tag, "_redir"},   {31'd0, bus.redirect_o}, 32'd0);
        chk({tag, "_mepc_d"},  bus.mepc_d_o,            32'd0);
        chk({tag, "_mstat_d"}, bus.mstatus_d_o,         32'd0);
        chk({tag, "_rpc"},     bus.redirect_pc_o,       32'd0);
    endtask

    // Called at the falling edge of acceptance cycle N; ends at the falling edge of N+3.
    task automatic run_seq(input string tag, input logic [31:0] exp_stall_n3, input bit raise_meip);
        chk({tag, "_stall_n"}, {31'd0, bus.stall_o},  32'd1);
        chk({tag, "_we_n"},    {31'd0, bus.we_exc_o}, 32'd0);
        @(posedge clk); #1;
        clear_events();
        bus.meip_i = raise_meip;
        @(negedge clk);
        chk({tag, "_we_n1"},    {31'd0, bus.we_exc_o}, 32'd1);
        chk({tag, "_stall_n1"}, {31'd0, bus.stall_o},  32'd1);
        @(negedge clk);
        chk({tag, "_redir_n2"}, {31'd0, bus.redirect_o}, 32'd1);
        @(negedge clk);
        chk({tag, "_stall_n3"}, {31'd0, bus.stall_o},    exp_stall_n3);
        chk({tag, "_redir_n3"}, {31'd0, bus.redirect_o}, 32'd0);
    endtask

    task automatic wait_stall(input string tag, input int limit, output int waited);
        waited = 0;
        @(negedge clk);
        while (!bus.stall_o && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.stall_o) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_timeout: no acceptance after %0d cycles", tag, limit);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.we_exc_o || bus.redirect_o) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_out: we=%0b redir=%0b with nothing expected",
                         bus.we_exc_o, bus.redirect_o);
            end else begin
                e = sb_q.pop_front();
                chk("sb_kind", {31'd0, bus.redirect_o}, {31'd0, e.is_redir});
                if (e.is_redir) begin
                    chk("sb_redirect_pc", bus.redirect_pc_o, e.pc);
                end else begin
                    chk("sb_mepc_d",    bus.mepc_d_o,    e.mepc);
                    chk("sb_mcause_d",  bus.mcause_d_o,  e.mcause);
                    chk("sb_mtval_d",   bus.mtval_d_o,   e.mtval);
                    chk("sb_mstatus_d", bus.mstatus_d_o, e.mstatus);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int waited;
        logic [31:0] vec_meip;
        logic [31:0] vec_msip;
        logic [31:0] vec_mti;
`ifdef TRAP_VECTORED_EN
        vec_meip = 32'hAC;
        vec_msip = 32'h8C;
        vec_mti  = 32'h9C;
`else
        vec_meip = 32'h80;
        vec_msip = 32'h80;
        vec_mti  = 32'h80;
`endif
        idle_inputs();
        rst = 1'b1;
        bus.exc_valid_i = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("rst_hold");
        @(posedge clk); #1;
        bus.exc_valid_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_idle");

        // 1: plain exception
        @(posedge clk); #1;
        bus.mstatus_i = 32'h8;  bus.mtvec_i = 32'h80;
        bus.exc_valid_i = 1'b1; bus.exc_cause_i = 4'd2;
        bus.exc_pc_i = 32'h100; bus.exc_tval_i = 32'hDEAD;
        push_trap(32'h100, 32'd2, 32'hDEAD, 32'h1880, 32'h80);
        @(negedge clk);
        run_seq("t1", 32'd0, 1'b0);

        // 1b: unaligned pc, MIE=0, vectored mode still uses base for exceptions
        @(posedge clk); #1;
        bus.mstatus_i = 32'h0;  bus.mtvec_i = 32'h1001;
        bus.exc_valid_i = 1'b1; bus.exc_cause_i = 4'd5;
        bus.exc_pc_i = 32'h103; bus.exc_tval_i = 32'h12345678;
        push_trap(32'h100, 32'd5, 32'h12345678, 32'h1800, 32'h1000);
        @(negedge clk);
        run_seq("t1b", 32'd0, 1'b0);

        // 2: all three interrupts pending, MEI wins; two-cycle synchroniser latency
        @(posedge clk); #1;
        bus.mstatus_i = 32'h8; bus.mie_i = 32'h888; bus.irq_ok_i = 1'b1;
        bus.next_pc_i = 32'h204; bus.mtvec_i = 32'h81;
        bus.meip_i = 1'b1; bus.msip_i = 1'b1; bus.mtip_i = 1'b1;
        push_trap(32'h204, 32'h8000000B, 32'h0, 32'h1880, vec_meip);
        wait_stall("t2", 8, waited);
        chk("t2_latency", 32'(waited), 32'd2);
        run_seq("t2", 32'd0, 1'b0);

        // 2b: MSI beats MTI
        @(posedge clk); #1;
        bus.msip_i = 1'b1; bus.mtip_i = 1'b1; bus.next_pc_i = 32'h3F0;
        push_trap(32'h3F0, 32'h80000003, 32'h0, 32'h1880, vec_msip);
        wait_stall("t2b", 8, waited);
        run_seq("t2b", 32'd0, 1'b0);

        // 2c: mie masks MEI and MSI, only MTI is taken
        @(posedge clk); #1;
        bus.mie_i = 32'h080;
        bus.meip_i = 1'b1; bus.msip_i = 1'b1; bus.mtip_i = 1'b1; bus.next_pc_i = 32'h40;
        push_trap(32'h40, 32'h80000007, 32'h0, 32'h1880, vec_mti);
        wait_stall("t2c", 8, waited);
        run_seq("t2c", 32'd0, 1'b0);

        // 3: MIE=0 blocks the timer interrupt, then MRET
        @(posedge clk); #1;
        bus.mstatus_i = 32'h80; bus.mie_i = 32'h80; bus.mtip_i = 1'b1; bus.mtvec_i = 32'h80;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_masked_stall", {31'd0, bus.stall_o}, 32'd0);
        end
        @(posedge clk); #1;
        bus.mret_i = 1'b1; bus.mepc_i = 32'h300; bus.mcause_i = 32'h8000000B; bus.mtval_i = 32'h55;
        push_trap(32'h300, 32'h8000000B, 32'h55, 32'h1888, 32'h300);
        @(negedge clk);
        run_seq("t3", 32'd0, 1'b0);

        // 3b: MRET with unaligned mepc and MPIE=0
        @(posedge clk); #1;
        bus.mstatus_i = 32'h8; bus.mie_i = 32'h0;
        bus.mret_i = 1'b1; bus.mepc_i = 32'h302; bus.mcause_i = 32'h2; bus.mtval_i = 32'h0;
        push_trap(32'h302, 32'h2, 32'h0, 32'h1880, 32'h300);
        @(negedge clk);
        run_seq("t3b", 32'd0, 1'b0);

        // 4a: exception and MRET together; only the exception runs
        @(posedge clk); #1;
        bus.mstatus_i = 32'h0; bus.mtvec_i = 32'h80; bus.mepc_i = 32'h999;
        bus.exc_valid_i = 1'b1; bus.exc_cause_i = 4'd8; bus.exc_pc_i = 32'h400; bus.exc_tval_i = 32'h0;
        bus.mret_i = 1'b1;
        push_trap(32'h400, 32'd8, 32'h0, 32'h1800, 32'h80);
        @(negedge clk);
        run_seq("t4a", 32'd0, 1'b0);

        // 4b: MEI raised during WRITE is accepted at N+3
        @(posedge clk); #1;
        bus.mstatus_i = 32'h8; bus.mie_i = 32'h800; bus.irq_ok_i = 1'b1;
        bus.next_pc_i = 32'h500; bus.mtvec_i = 32'h81;
        bus.exc_valid_i = 1'b1; bus.exc_cause_i = 4'd2; bus.exc_pc_i = 32'h600; bus.exc_tval_i = 32'h7;
        push_trap(32'h600, 32'd2, 32'h7, 32'h1880, 32'h80);
        push_trap(32'h500, 32'h8000000B, 32'h0, 32'h1880, vec_meip);
        @(negedge clk);
        run_seq("t4b", 32'd1, 1'b1);
        run_seq("t4b_irq", 32'd0, 1'b0);

        // 5: reset during WRITE aborts the sequence
        @(posedge clk); #1;
        bus.exc_valid_i = 1'b1; bus.exc_cause_i = 4'd1; bus.exc_pc_i = 32'h700;
        @(negedge clk);
        chk("t5_stall_n", {31'd0, bus.stall_o}, 32'd1);
        @(posedge clk); #1;
        clear_events();
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("t5_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_no_redir", {31'd0, bus.redirect_o}, 32'd0);
            chk("t5_no_stall", {31'd0, bus.stall_o},    32'd0);
        end

        // 6: one-cycle MEI pulse at cycle K is accepted at K+2
        @(posedge clk); #1;
        bus.mstatus_i = 32'h8; bus.mie_i = 32'h800; bus.irq_ok_i = 1'b1;
        bus.next_pc_i = 32'h800; bus.mtvec_i = 32'h80;
        bus.meip_i = 1'b1;
        @(negedge clk);
        chk("t6_stall_k", {31'd0, bus.stall_o}, 32'd0);
        @(posedge clk); #1;
        bus.meip_i = 1'b0;
        push_trap(32'h800, 32'h8000000B, 32'h0, 32'h1880, 32'h80);
        @(negedge clk);
        chk("t6_stall_k1", {31'd0, bus.stall_o}, 32'd0);
        @(negedge clk);
        run_seq("t6", 32'd0, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
